// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 mux with valid/ready on every port. Selection is either an
// external select or round-robin. One output register stage, full throughput.

// Per-channel request qualification and ready decode.
module mux_rr_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  input  logic             load_en,
  input  logic             gnt_vld,
  input  logic [SEL_W-1:0] gnt,
  output logic             req,
  output logic             ready
);
  // In explicit mode only the selected channel may request, so the shared
  // round-robin search below can serve both modes.
  assign req   = valid && (mode || (s == SEL_W'(IDX)));
  assign ready = load_en && gnt_vld && (gnt == SEL_W'(IDX));
endmodule

module mux_rr_nto1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   s,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        xfer_cnt
);
  if (SEL_W != $clog2(N)) begin : g_bad_sel_w
    $error("mux_rr_nto1: SEL_W must equal clog2(N)");
  end

  logic [N-1:0][WIDTH-1:0] lanes;
  logic [N-1:0]            req;
  logic [SEL_W-1:0]        rr_ptr;
  logic [SEL_W-1:0]        gnt;
  logic                    gnt_vld;
  logic                    load_en;

  assign lanes   = in_data;
  assign load_en = !out_valid || out_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_rr_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .valid   (in_valid[i]),
      .mode    (mode),
      .s       (s),
      .load_en (load_en),
      .gnt_vld (gnt_vld),
      .gnt     (gnt),
      .req     (req[i]),
      .ready   (in_ready[i])
    );
  end

  // Search starts one past the last winner and wraps; at most one req bit is
  // set in explicit mode, so rr_ptr has no effect there.
  always_comb begin
    int c;
    gnt_vld = 1'b0;
    gnt     = '0;
    c       = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N) c = c - N;
      if (!gnt_vld && req[c]) begin
        gnt_vld = 1'b1;
        gnt     = SEL_W'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
      rr_ptr    <= SEL_W'(N-1);
    end else begin
      if (load_en) begin
        if (gnt_vld) begin
          out_data  <= lanes[gnt];
          out_sel   <= gnt;
          out_valid <= 1'b1;
          if (mode) rr_ptr <= gnt;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
endmodule
